// File: rtl/ahb_bridge_pkg.sv
// ---------------------------------------------------------------------------
// ahb_bridge_pkg
// Shared types and constants for the wide AHB-lite to narrow core bridge.
//   state_t      : bridge FSM states (IDLE, BEAT, ERR1, ERR2)
//   HTRANS_*     : AHB transfer type encodings
//   HSIZE_*      : AHB transfer size encodings up to 128 bits
// ---------------------------------------------------------------------------
package ahb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BEAT = 2'b01,
    ERR1 = 2'b10,
    ERR2 = 2'b11
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;
  localparam logic [2:0] HSIZE_QWORD = 3'b100;

endpackage

// File: rtl/ahb_xfer_check.sv
// ---------------------------------------------------------------------------
// ahb_xfer_check
// Combinational legality check of an AHB address phase and beat count.
//   addr   in  AHB_ADDR_WIDTH  byte address from the address phase
//   size   in  3               hsize of the address phase
//   nbeats out                 number of core beats the transfer needs
//   err    out 1               size too large, misaligned or outside window
// ---------------------------------------------------------------------------
module ahb_xfer_check
  import ahb_bridge_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH    = 32,
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int CLIENT_DATA_WIDTH = 32,
  parameter int WIN_BASE          = 0,
  parameter int WIN_SIZE          = 4096,
  localparam int NBW = $clog2(AHB_DATA_WIDTH / CLIENT_DATA_WIDTH) + 1
) (
  input  logic [AHB_ADDR_WIDTH-1:0] addr,
  input  logic [2:0]                size,
  output logic [NBW-1:0]            nbeats,
  output logic                      err
);

  localparam int MAX_SIZE    = $clog2(AHB_DATA_WIDTH / 8);
  localparam int CLIENT_SIZE = $clog2(CLIENT_DATA_WIDTH / 8);
  localparam logic [AHB_ADDR_WIDTH:0] LO  = (AHB_ADDR_WIDTH + 1)'(WIN_BASE);
  localparam logic [AHB_ADDR_WIDTH:0] LEN = (AHB_ADDR_WIDTH + 1)'(WIN_SIZE);

  logic [7:0]              mask;
  logic [AHB_ADDR_WIDTH:0] offset;
  logic                    bad_size;
  logic                    bad_align;
  logic                    bad_win;

  // An address below the window base wraps the offset into the extra top
  // bit, so a single unsigned compare covers both window edges.
  always_comb begin
    mask      = (8'd1 << size) - 8'd1;
    offset    = {1'b0, addr} - LO;
    bad_size  = size > 3'(MAX_SIZE);
    bad_align = |(addr[7:0] & mask);
    bad_win   = offset >= LEN;
    err       = bad_size | bad_align | bad_win;
    if (size <= 3'(CLIENT_SIZE)) begin
      nbeats = NBW'(1);
    end else begin
      nbeats = NBW'(8'd1 << (size - 3'(CLIENT_SIZE)));
    end
  end

endmodule

// File: rtl/ahb_wide_slv_bridge.sv
// ---------------------------------------------------------------------------
// ahb_wide_slv_bridge
// AHB-lite slave that splits wide transfers into core-width beats, honours
// core hold as wait states and returns two-cycle ERROR responses.
//   clk, reset_n        clock, synchronous active-low reset
//   haddr_i..hsize_i    AHB address/data phase inputs
//   hresp_o, hreadyout_o, hrdata_o   AHB response
//   cs_o, we_o, addr_o, wdata_o      core register port request
//   rdata_i, hld_i, err_i            core register port response
// ---------------------------------------------------------------------------
module ahb_wide_slv_bridge
  import ahb_bridge_pkg::*;
#(
  parameter int AHB_ADDR_WIDTH    = 32,
  parameter int AHB_DATA_WIDTH    = 64,
  parameter int CLIENT_DATA_WIDTH = 32,
  parameter int WIN_BASE          = 0,
  parameter int WIN_SIZE          = 4096,
  parameter int MAX_HOLD          = 255
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [AHB_ADDR_WIDTH-1:0]    haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0]    hwdata_i,
  input  logic                         hsel_i,
  input  logic                         hwrite_i,
  input  logic                         hready_i,
  input  logic [1:0]                   htrans_i,
  input  logic [2:0]                   hsize_i,
  output logic                         hresp_o,
  output logic                         hreadyout_o,
  output logic [AHB_DATA_WIDTH-1:0]    hrdata_o,
  output logic                         cs_o,
  output logic                         we_o,
  output logic [AHB_ADDR_WIDTH-1:0]    addr_o,
  output logic [CLIENT_DATA_WIDTH-1:0] wdata_o,
  input  logic [CLIENT_DATA_WIDTH-1:0] rdata_i,
  input  logic                         hld_i,
  input  logic                         err_i
);

  localparam int R   = AHB_DATA_WIDTH / CLIENT_DATA_WIDTH;
  localparam int CW  = CLIENT_DATA_WIDTH;
  localparam int BW  = (R > 1) ? $clog2(R) : 1;
  localparam int NBW = $clog2(R) + 1;
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  state_t                    state;
  logic [BW-1:0]             idx;
  logic [BW-1:0]             last_idx;
  logic [HCW-1:0]            hold_cnt;
  logic                      first;
  logic [AHB_DATA_WIDTH-1:0] wbuf;
  logic [AHB_DATA_WIDTH-1:0] rbuf;
  logic [NBW-1:0]            nbeats;
  logic                      chk_err;
  logic                      accept;
  logic                      beat_done;
  logic                      last_done;
  logic                      timeout;

  ahb_xfer_check #(
    .AHB_ADDR_WIDTH    (AHB_ADDR_WIDTH),
    .AHB_DATA_WIDTH    (AHB_DATA_WIDTH),
    .CLIENT_DATA_WIDTH (CLIENT_DATA_WIDTH),
    .WIN_BASE          (WIN_BASE),
    .WIN_SIZE          (WIN_SIZE)
  ) u_check (
    .addr   (haddr_i),
    .size   (hsize_i),
    .nbeats (nbeats),
    .err    (chk_err)
  );

  assign beat_done = (state == BEAT) & ~hld_i & ~err_i;
  assign last_done = beat_done & (idx == last_idx);
  assign timeout   = (MAX_HOLD != 0) && (state == BEAT) && hld_i &&
                     (hold_cnt == HCW'(MAX_HOLD - 1));

  // Only an address phase seen while our own data phase completes is taken,
  // which rules out ERR1 and gives back-to-back transfers with no gap.
  assign accept = hsel_i & hready_i & hreadyout_o &
                  ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));

  assign cs_o    = (state == BEAT);
  assign hresp_o = (state == ERR1) | (state == ERR2);

  // hreadyout depends on the live hold/error so that an unheld last beat
  // completes in the same cycle the core answers.
  always_comb begin
    hreadyout_o = 1'b1;
    case (state)
      BEAT:    hreadyout_o = last_done;
      ERR1:    hreadyout_o = 1'b0;
      default: hreadyout_o = 1'b1;
    endcase
  end

  // Beat 0 takes its write lane straight from the bus in the first data
  // cycle; later beats and any held beat 0 use the captured copy.
  always_comb begin
    wdata_o = '0;
    if (cs_o && we_o) begin
      wdata_o = first ? hwdata_i[idx*CW +: CW] : wbuf[idx*CW +: CW];
    end
  end

  // Earlier read lanes come from the buffer; the final lane is forwarded
  // from the core so the read completes without an extra cycle.
  always_comb begin
    hrdata_o = rbuf;
    if (cs_o && !we_o && (idx == last_idx)) begin
      hrdata_o[idx*CW +: CW] = rdata_i;
    end
  end

  // Bridge FSM: beat sequencing, hold timeout, error response and the
  // pipelined launch of the next transfer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      hold_cnt <= '0;
      first    <= 1'b0;
      we_o     <= 1'b0;
      addr_o   <= '0;
      wbuf     <= '0;
      rbuf     <= '0;
    end else begin
      first <= 1'b0;
      if (cs_o && first) begin
        wbuf <= hwdata_i;
      end
      if (beat_done && !we_o) begin
        rbuf[idx*CW +: CW] <= rdata_i;
      end
      case (state)
        BEAT: begin
          if (hld_i) begin
            if (timeout) begin
              state    <= ERR1;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + HCW'(1);
            end
          end else if (err_i) begin
            state    <= ERR1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= '0;
            if (idx != last_idx) begin
              idx    <= idx + BW'(1);
              addr_o <= addr_o + AHB_ADDR_WIDTH'(CW / 8);
            end else begin
              state <= IDLE;
            end
          end
        end
        ERR1:    state <= ERR2;
        default: state <= IDLE;
      endcase
      if (accept) begin
        addr_o   <= haddr_i;
        we_o     <= hwrite_i;
        idx      <= '0;
        hold_cnt <= '0;
        if (chk_err) begin
          state <= ERR1;
        end else begin
          state    <= BEAT;
          last_idx <= BW'(nbeats - NBW'(1));
          first    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_wide_slv_bridge.sv
// ---------------------------------------------------------------------------
// tb_ahb_wide_slv_bridge
// Directed bench for ahb_wide_slv_bridge (64-bit bus, 32-bit core).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_ahb_wide_slv_bridge;
  import ahb_bridge_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] haddr;
  logic [63:0] hwdata;
  logic        hsel;
  logic        hwrite;
  logic        hready;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hresp;
  logic        hreadyout;
  logic [63:0] hrdata;
  logic        cs;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hld;
  logic        err;

  int vec_count  = 0;
  int miss_count = 0;

  ahb_wide_slv_bridge #(
    .AHB_ADDR_WIDTH    (32),
    .AHB_DATA_WIDTH    (64),
    .CLIENT_DATA_WIDTH (32),
    .WIN_BASE          (0),
    .WIN_SIZE          (4096),
    .MAX_HOLD          (255)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .haddr_i     (haddr),
    .hwdata_i    (hwdata),
    .hsel_i      (hsel),
    .hwrite_i    (hwrite),
    .hready_i    (hready),
    .htrans_i    (htrans),
    .hsize_i     (hsize),
    .hresp_o     (hresp),
    .hreadyout_o (hreadyout),
    .hrdata_o    (hrdata),
    .cs_o        (cs),
    .we_o        (we),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .rdata_i     (rdata),
    .hld_i       (hld),
    .err_i       (err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so a broken design can never stall the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when it disagrees
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an address phase
  task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [2:0] s);
    hsel   = 1'b1;
    hready = 1'b1;
    htrans = HTRANS_NONSEQ;
    haddr  = a;
    hwrite = w;
    hsize  = s;
  endtask

  task automatic busIdle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    haddr  = 32'h0;
    hwrite = 1'b0;
    hsize  = HSIZE_BYTE;
  endtask

  // Fault vectors: window, misaligned dword, oversize, misaligned half
  logic [31:0] fault_addr [4] = '{32'h0000_1004, 32'h0000_0004, 32'h0000_0040, 32'h0000_0003};
  logic [2:0]  fault_size [4] = '{HSIZE_WORD, HSIZE_DWORD, HSIZE_QWORD, HSIZE_HALF};

  initial begin
    reset_n = 1'b0;
    hready  = 1'b1;
    hwdata  = 64'h0;
    rdata   = 32'h0;
    hld     = 1'b0;
    err     = 1'b0;
    busIdle();

    // Reset state
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_hreadyout", 64'(hreadyout), 64'd1);
    checkOutput("rst_hresp",     64'(hresp),     64'd0);
    checkOutput("rst_hrdata",    hrdata,         64'h0);
    checkOutput("rst_cs",        64'(cs),        64'd0);
    checkOutput("rst_we",        64'(we),        64'd0);
    checkOutput("rst_addr",      64'(addr),      64'h0);
    checkOutput("rst_wdata",     64'(wdata),     64'h0);
    tick();
    reset_n = 1'b1;

    // BUSY with select: zero-wait OKAY, no core beat
    tick();
    applyStimulus(32'h10, 1'b1, HSIZE_DWORD);
    htrans = HTRANS_BUSY;
    tick();
    busIdle();
    @(negedge clk);
    checkOutput("busy_cs",        64'(cs),        64'd0);
    checkOutput("busy_hreadyout", 64'(hreadyout), 64'd1);

    // 64-bit write at 0x10, no hold
    tick();
    applyStimulus(32'h10, 1'b1, HSIZE_DWORD);
    tick();
    busIdle();
    hwdata = 64'h1122_3344_5566_7788;
    @(negedge clk);
    checkOutput("wr_t1_cs",        64'(cs),        64'd1);
    checkOutput("wr_t1_we",        64'(we),        64'd1);
    checkOutput("wr_t1_addr",      64'(addr),      64'h10);
    checkOutput("wr_t1_wdata",     64'(wdata),     64'h5566_7788);
    checkOutput("wr_t1_hreadyout", 64'(hreadyout), 64'd0);
    tick();
    hwdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    checkOutput("wr_t2_addr",      64'(addr),      64'h14);
    checkOutput("wr_t2_wdata",     64'(wdata),     64'h1122_3344);
    checkOutput("wr_t2_hreadyout", 64'(hreadyout), 64'd1);
    checkOutput("wr_t2_hresp",     64'(hresp),     64'd0);
    tick();
    @(negedge clk);
    checkOutput("wr_t3_cs", 64'(cs), 64'd0);

    // 64-bit read at 0x20, beat 1 held for 3 cycles
    tick();
    applyStimulus(32'h20, 1'b0, HSIZE_DWORD);
    tick();
    busIdle();
    rdata = 32'hAAAA_0000;
    @(negedge clk);
    checkOutput("rd_t1_we",        64'(we),        64'd0);
    checkOutput("rd_t1_addr",      64'(addr),      64'h20);
    checkOutput("rd_t1_hreadyout", 64'(hreadyout), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      hld   = 1'b1;
      rdata = 32'h0;
      @(negedge clk);
      checkOutput("rd_hold_hreadyout", 64'(hreadyout), 64'd0);
      checkOutput("rd_hold_addr",      64'(addr),      64'h24);
    end
    tick();
    hld   = 1'b0;
    rdata = 32'h0000_BBBB;
    @(negedge clk);
    checkOutput("rd_t5_hreadyout", 64'(hreadyout), 64'd1);
    checkOutput("rd_t5_hrdata",    hrdata,         64'h0000_BBBB_AAAA_0000);
    checkOutput("rd_t5_hresp",     64'(hresp),     64'd0);

    // 32-bit read at 0x08, single beat
    tick();
    applyStimulus(32'h08, 1'b0, HSIZE_WORD);
    tick();
    busIdle();
    rdata = 32'h1234_5678;
    @(negedge clk);
    checkOutput("nr_cs",        64'(cs),           64'd1);
    checkOutput("nr_addr",      64'(addr),         64'h08);
    checkOutput("nr_hreadyout", 64'(hreadyout),    64'd1);
    checkOutput("nr_hrdata",    64'(hrdata[31:0]), 64'h1234_5678);

    // Byte read at 0x81, single beat, unaligned byte is legal
    tick();
    applyStimulus(32'h81, 1'b0, HSIZE_BYTE);
    tick();
    busIdle();
    @(negedge clk);
    checkOutput("byte_addr",      64'(addr),      64'h81);
    checkOutput("byte_hreadyout", 64'(hreadyout), 64'd1);

    // 64-bit write with core error on beat 0
    tick();
    applyStimulus(32'h30, 1'b1, HSIZE_DWORD);
    tick();
    busIdle();
    hwdata = 64'h0123_4567_89AB_CDEF;
    err    = 1'b1;
    @(negedge clk);
    checkOutput("cerr_t1_hresp",     64'(hresp),     64'd0);
    checkOutput("cerr_t1_hreadyout", 64'(hreadyout), 64'd0);
    tick();
    err = 1'b0;
    @(negedge clk);
    checkOutput("cerr_e_hresp",     64'(hresp),     64'd1);
    checkOutput("cerr_e_hreadyout", 64'(hreadyout), 64'd0);
    checkOutput("cerr_e_cs",        64'(cs),        64'd0);
    tick();
    @(negedge clk);
    checkOutput("cerr_e1_hresp",     64'(hresp),     64'd1);
    checkOutput("cerr_e1_hreadyout", 64'(hreadyout), 64'd1);
    tick();
    @(negedge clk);
    checkOutput("cerr_after_cs", 64'(cs), 64'd0);

    // Address-phase faults: two-cycle ERROR, no core beat
    for (int f = 0; f < 4; f++) begin
      tick();
      applyStimulus(fault_addr[f], 1'b1, fault_size[f]);
      tick();
      busIdle();
      @(negedge clk);
      checkOutput($sformatf("fault%0d_e_hresp", f),     64'(hresp),     64'd1);
      checkOutput($sformatf("fault%0d_e_hreadyout", f), 64'(hreadyout), 64'd0);
      checkOutput($sformatf("fault%0d_e_cs", f),        64'(cs),        64'd0);
      tick();
      @(negedge clk);
      checkOutput($sformatf("fault%0d_e1_hresp", f),     64'(hresp),     64'd1);
      checkOutput($sformatf("fault%0d_e1_hreadyout", f), 64'(hreadyout), 64'd1);
      checkOutput($sformatf("fault%0d_e1_cs", f),        64'(cs),        64'd0);
    end

    // Back-to-back narrow writes with no dead cycle
    tick();
    applyStimulus(32'h50, 1'b1, HSIZE_WORD);
    tick();
    applyStimulus(32'h58, 1'b1, HSIZE_WORD);
    hwdata = 64'h0000_0000_CAFE_F00D;
    @(negedge clk);
    checkOutput("b2b_a_addr",      64'(addr),      64'h50);
    checkOutput("b2b_a_wdata",     64'(wdata),     64'hCAFE_F00D);
    checkOutput("b2b_a_hreadyout", 64'(hreadyout), 64'd1);
    tick();
    busIdle();
    hwdata = 64'h0000_0000_0BAD_BEEF;
    @(negedge clk);
    checkOutput("b2b_b_cs",    64'(cs),    64'd1);
    checkOutput("b2b_b_addr",  64'(addr),  64'h58);
    checkOutput("b2b_b_wdata", 64'(wdata), 64'h0BAD_BEEF);

    // Hold timeout: 255 consecutive held cycles give an ERROR
    tick();
    applyStimulus(32'h60, 1'b0, HSIZE_WORD);
    tick();
    busIdle();
    hld = 1'b1;
    for (int i = 1; i < 255; i++) tick();
    @(negedge clk);
    checkOutput("to_t255_hresp",     64'(hresp),     64'd0);
    checkOutput("to_t255_cs",        64'(cs),        64'd1);
    checkOutput("to_t255_hreadyout", 64'(hreadyout), 64'd0);
    tick();
    hld = 1'b0;
    @(negedge clk);
    checkOutput("to_e_hresp",     64'(hresp),     64'd1);
    checkOutput("to_e_hreadyout", 64'(hreadyout), 64'd0);
    checkOutput("to_e_cs",        64'(cs),        64'd0);
    tick();
    @(negedge clk);
    checkOutput("to_e1_hresp",     64'(hresp),     64'd1);
    checkOutput("to_e1_hreadyout", 64'(hreadyout), 64'd1);

    // Reset in the middle of a 64-bit write
    tick();
    applyStimulus(32'h70, 1'b1, HSIZE_DWORD);
    tick();
    busIdle();
    hwdata = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    checkOutput("mrst_t1_cs", 64'(cs), 64'd1);
    reset_n = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("mrst_hreadyout", 64'(hreadyout), 64'd1);
    checkOutput("mrst_cs",        64'(cs),        64'd0);
    checkOutput("mrst_hrdata",    hrdata,         64'h0);
    reset_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
